serial_frame_tx: RTL and testbench

Serial frame transmitter, the transmit end of the team's serial sync-pattern detector link. It accepts a parallel payload word over a valid/ready handshake. It then shifts out, one bit per clock, a fixed sync header (default 1001), the payload MSB-first, and a programmable idle gap of zeros. The serial line feeds the detector side, which locks on the header.

---
 rtl/serial_link_pkg.sv | 23 ++
 rtl/piso_shift.sv | 28 ++
 rtl/serial_frame_tx.sv | 113 +++++++++++
 tb/tb_serial_frame_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial sync-pattern link.
// Both the transmitter and the detector take their header from here.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    GAP
  } state_t;

  localparam int SYNC_W_DEF = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1001;

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register.
// Load has priority over shift.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload,
// then an idle gap of zeros, one bit per clock.
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int GAP_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXW = max3(SYNC_W, DATA_W, (GAP_W > 1) ? GAP_W : 1);
  localparam int CW = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_W > 0) ? GAP_W - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          hdr_bit;
  logic          pay_bit;

  assign accept = (state == IDLE) && in_valid;

  piso_shift #(.W(SYNC_W)) u_hdr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == SYNC),
    .din   (SYNC_PAT),
    .msb   (hdr_bit)
  );

  piso_shift #(.W(DATA_W)) u_pay (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == DATA),
    .din   (in_data),
    .msb   (pay_bit)
  );

  // cnt restarts at zero on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SYNC;
            cnt   <= '0;
          end
        end
        SYNC: begin
          if (cnt == SYNC_LAST) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
            state <= (GAP_W == 0) ? IDLE : GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ser_out = 1'b0;
    unique case (1'b1)
      (state == SYNC): ser_out = hdr_bit;
      (state == DATA): ser_out = pay_bit;
      default: ser_out = 1'b0;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign ser_valid  = (state == SYNC) || (state == DATA);
  assign frame_done = (state == DATA) && (cnt == DATA_LAST);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx with a frame-level
// reference model and a behavioural 1001 detector on the line.
module tb_serial_frame_tx;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam int GW = 2;
  localparam logic [SW-1:0] PAT = 4'b1001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic sel = 1'b0;

  logic v0, rdy0, so0, sv0, bz0, fd0;
  logic v1, rdy1, so1, sv1, bz1, fd1;
  logic rdy, so, sv, bz, fd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int flags = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign v0  = in_valid & ~sel;
  assign v1  = in_valid & sel;
  assign rdy = sel ? rdy1 : rdy0;
  assign so  = sel ? so1 : so0;
  assign sv  = sel ? sv1 : sv0;
  assign bz  = sel ? bz1 : bz0;
  assign fd  = sel ? fd1 : fd0;

  serial_frame_tx #(
    .DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(PAT), .GAP_W(GW)
  ) dut0 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (v0),
    .in_ready   (rdy0),
    .ser_out    (so0),
    .ser_valid  (sv0),
    .busy       (bz0),
    .frame_done (fd0)
  );

  serial_frame_tx #(
    .DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(PAT), .GAP_W(0)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (v1),
    .in_ready   (rdy1),
    .ser_out    (so1),
    .ser_valid  (sv1),
    .busy       (bz1),
    .frame_done (fd1)
  );

  // Starts and ends at a falling edge. Model: the frame is the
  // header bits, payload MSB-first, then gap zeros; in_ready
  // comes back one cycle after the last of those.
  task automatic send_frame(
    input logic [DW-1:0] d,
    input int gap,
    input bit noise,
    input bit hold,
    input logic [DW-1:0] nxt
  );
    int n;
    int len;
    logic bits[$];
    logic [4:0] got;
    logic [4:0] exp;
    logic [3:0] win;
    int nv;
    bit lock;
    bit hit;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL accept_wait in_ready=%b required=1", rdy);
      return;
    end
    in_valid = 1'b1;
    in_data = d;
    bits = {};
    for (int i = 0; i < SW; i++) bits.push_back(PAT[SW-1-i]);
    for (int i = 0; i < DW; i++) bits.push_back(d[DW-1-i]);
    for (int i = 0; i < gap; i++) bits.push_back(1'b0);
    len = SW + DW + gap;
    win = '0;
    nv = 0;
    lock = 1'b0;
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1) acc_cyc = cyc;
      exp = {((c <= len) ? bits[c-1] : 1'b0), (c <= SW + DW),
             (c == SW + DW), (c == len + 1), (c != len + 1)};
      got = {so, sv, fd, rdy, bz};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL frame d=%h cyc=%0d {out,valid,done,ready,busy}=%b required=%b",
                 d, c, got, exp);
      end
      hit = 1'b0;
      if (sv) begin
        win = {win[2:0], so};
        nv++;
        hit = !lock && nv >= SW && win == PAT;
        if (hit) begin
          lock = 1'b1;
          flags++;
        end
      end else begin
        lock = 1'b0;
        nv = 0;
      end
      checks++;
      if (hit !== (c == SW)) begin
        failures++;
        $display("FAIL detect d=%h cyc=%0d flag=%b required=%b", d, c, hit, (c == SW));
      end
      if (c <= len) begin
        in_valid = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        in_data = hold ? nxt : ((c == SW + 1) ? 8'h3C : DW'($urandom));
      end else begin
        in_valid = hold;
        in_data = nxt;
      end
    end
  endtask

  task automatic check_idle(input int n, input string nm);
    logic [4:0] got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {so, sv, fd, rdy, bz};
      checks++;
      if (got !== 5'b00010) begin
        failures++;
        $display("FAIL %s cyc=%0d {out,valid,done,ready,busy}=%b required=00010", nm, i, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    got = {so0, sv0, fd0, rdy0, bz0};
    checks++;
    if (got !== 5'b00010) begin
      failures++;
      $display("FAIL reset_state got=%b required=00010", got);
    end
    reset = 1'b1;
    check_idle(10, "reset_idle");
  endtask

  task automatic test_single();
    send_frame(8'hA5, GW, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    int a1;
    send_frame(8'hFF, GW, 1'b0, 1'b1, 8'h00);
    a1 = acc_cyc;
    send_frame(8'h00, GW, 1'b0, 1'b0, '0);
    checks++;
    if (acc_cyc - a1 != SW + DW + GW + 1) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d required=%0d", acc_cyc - a1, SW + DW + GW + 1);
    end
  endtask

  task automatic test_mid_change();
    send_frame(8'hA5, GW, 1'b1, 1'b0, '0);
    check_idle(4, "no_queued_frame");
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (SW + 3) @(negedge clk);
    #2 reset = 1'b0;
    #1 got = {so0, sv0, fd0, rdy0, bz0};
    checks++;
    if (got !== 5'b00010) begin
      failures++;
      $display("FAIL async_reset got=%b required=00010", got);
    end
    @(negedge clk);
    reset = 1'b1;
    check_idle(6, "after_reset");
    send_frame(8'h81, GW, 1'b0, 1'b0, '0);
  endtask

  task automatic test_loopback();
    int a1;
    flags = 0;
    send_frame(8'h00, GW, 1'b0, 1'b0, '0);
    send_frame(8'hA5, GW, 1'b0, 1'b0, '0);
    checks++;
    if (flags != 2) begin
      failures++;
      $display("FAIL loop_flags got=%0d required=2", flags);
    end
    sel = 1'b1;
    @(negedge clk);
    send_frame(DW'($urandom), 0, 1'b1, 1'b1, 8'h5A);
    a1 = acc_cyc;
    send_frame(8'h5A, 0, 1'b0, 1'b0, '0);
    checks++;
    if (acc_cyc - a1 != SW + DW + 1) begin
      failures++;
      $display("FAIL gap0_spacing got=%0d required=%0d", acc_cyc - a1, SW + DW + 1);
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      send_frame(DW'($urandom), GW, 1'($urandom), 1'b0, '0);
    end
    check_idle(3, "random_tail");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_change();
    test_async_reset();
    test_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
